// File: rtl/pc_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pc_sequencer_if
// Description : Instruction-memory, decode and redirect signals of the fetch
//               controller, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_data, inst_ready,
               redir_valid, redir_sel, redir_pc, redir_imm
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_data, inst_ready,
               redir_valid, redir_sel, redir_pc, redir_imm
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pc_sequencer
// Description : Stall- and squash-aware fetch sequencer owning the PC.
//               Define PC_DELAY_SLOT_EN to deliver the delay-slot instruction
//               instead of squashing it on a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0020
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        bus,
    output logic [31:0]           fetch_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    logic [1:0]  r_state,       w_state_nx;
    logic [31:0] r_pc,          w_pc_nx;
    logic        r_pend,        w_pend_nx;
    logic [31:0] r_tgt,         w_tgt_nx;
    logic        r_inst_valid,  w_inst_valid_nx;
    logic [31:0] r_inst,        w_inst_nx;
    logic [31:0] r_inst_pc,     w_inst_pc_nx;
    logic [31:0] r_fetch_count, w_fetch_count_nx;
    logic        r_imem_req;

    logic        w_redir;
    logic [31:0] w_redir_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // Selector codes 00/11 are not redirects at all.
    assign w_redir     = bus.redir_valid &
                         ((bus.redir_sel == 2'b01) | (bus.redir_sel == 2'b10));
    assign w_redir_pc4 = bus.redir_pc + 32'd4;
    assign w_br_off    = {{14{bus.redir_imm[15]}}, bus.redir_imm[15:0], 2'b00};
    assign w_jmp_tgt   = {w_redir_pc4[31:28], bus.redir_imm, 2'b00};
    assign w_target    = (bus.redir_sel == 2'b10) ? w_jmp_tgt : (w_redir_pc4 + w_br_off);
    assign w_pc_inc    = r_pc + 32'd4;

    always_comb begin
        w_state_nx       = r_state;
        w_pc_nx          = r_pc;
        w_pend_nx        = r_pend;
        w_tgt_nx         = r_tgt;
        w_inst_valid_nx  = r_inst_valid;
        w_inst_nx        = r_inst;
        w_inst_pc_nx     = r_inst_pc;
        w_fetch_count_nx = r_fetch_count;

        case (r_state)
            c_IDLE: begin
                w_state_nx = c_REQ;
                if (w_redir)
                    w_pc_nx = w_target;
            end

            c_REQ: begin
`ifdef PC_DELAY_SLOT_EN
                if (bus.imem_ack) begin
                    w_inst_nx       = bus.imem_data;
                    w_inst_pc_nx    = r_pc;
                    w_inst_valid_nx = 1'b1;
                    w_pend_nx       = 1'b0;
                    w_state_nx      = c_HOLD;
                    // A redirect in the ack cycle is newer than a latched one.
                    if (w_redir)
                        w_pc_nx = w_target;
                    else if (r_pend)
                        w_pc_nx = r_tgt;
                    else
                        w_pc_nx = w_pc_inc;
                end else if (w_redir) begin
                    w_pend_nx = 1'b1;
                    w_tgt_nx  = w_target;
                end
`else
                if (bus.imem_ack) begin
                    if (w_redir) begin
                        w_pc_nx   = w_target;
                        w_pend_nx = 1'b0;
                    end else if (r_pend) begin
                        w_pc_nx   = r_tgt;
                        w_pend_nx = 1'b0;
                    end else begin
                        w_inst_nx       = bus.imem_data;
                        w_inst_pc_nx    = r_pc;
                        w_inst_valid_nx = 1'b1;
                        w_pc_nx         = w_pc_inc;
                        w_state_nx      = c_HOLD;
                    end
                end else if (w_redir) begin
                    // The outstanding request must complete before the squash.
                    w_pend_nx = 1'b1;
                    w_tgt_nx  = w_target;
                end
`endif
            end

            c_HOLD: begin
`ifdef PC_DELAY_SLOT_EN
                if (w_redir)
                    w_pc_nx = w_target;
                if (bus.inst_ready) begin
                    w_inst_valid_nx  = 1'b0;
                    w_fetch_count_nx = r_fetch_count + 32'd1;
                    w_state_nx       = c_REQ;
                end
`else
                if (w_redir) begin
                    w_inst_valid_nx = 1'b0;
                    w_pc_nx         = w_target;
                    w_state_nx      = c_REQ;
                end else if (bus.inst_ready) begin
                    w_inst_valid_nx  = 1'b0;
                    w_fetch_count_nx = r_fetch_count + 32'd1;
                    w_state_nx       = c_REQ;
                end
`endif
            end

            default: w_state_nx = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_pc          <= RESET_PC;
            r_pend        <= 1'b0;
            r_tgt         <= 32'd0;
            r_inst_valid  <= 1'b0;
            r_inst        <= 32'd0;
            r_inst_pc     <= 32'd0;
            r_fetch_count <= 32'd0;
            r_imem_req    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_pc          <= w_pc_nx;
            r_pend        <= w_pend_nx;
            r_tgt         <= w_tgt_nx;
            r_inst_valid  <= w_inst_valid_nx;
            r_inst        <= w_inst_nx;
            r_inst_pc     <= w_inst_pc_nx;
            r_fetch_count <= w_fetch_count_nx;
            r_imem_req    <= (w_state_nx == c_REQ);
        end
    end

    // The PC register drives the address bus directly, so the address is
    // stable for the whole life of a request.
    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Randomized bench for pc_sequencer against a transaction model,
//               plus directed literal checks. Honours PC_DELAY_SLOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] c_RESET_PC = 32'h0040_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_count;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(c_RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: what the fetch unit is doing, expressed as "waiting to start",
    // "request outstanding" or "instruction held", plus a pending target.
    bit          m_idle, m_req, m_hold, m_pend;
    logic [31:0] m_pc, m_tgt, m_inst, m_ipc, m_cnt;

    bit          mem_busy;
    int          mem_wait;
    logic [31:0] addr_q[$];
    int          cyc_q[$];

    function automatic logic [31:0] f_target(input logic [1:0] sel,
                                              input logic [31:0] rpc,
                                              input logic [25:0] imm);
        logic [31:0] nxt;
        int          off;
        nxt = rpc + 32'd4;
        if (sel == 2'b10)
            return (nxt & 32'hF000_0000) | (32'(imm) << 2);
        off = int'($signed(imm[15:0])) * 4;
        return nxt + 32'(off);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_req = 1'b0; m_hold = 1'b0; m_pend = 1'b0;
        m_pc = c_RESET_PC; m_tgt = 32'd0; m_inst = 32'd0; m_ipc = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic model_adv();
        bit          rv;
        logic [31:0] t;
        rv = bus.redir_valid && (bus.redir_sel == 2'b01 || bus.redir_sel == 2'b10);
        t  = f_target(bus.redir_sel, bus.redir_pc, bus.redir_imm);
        if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
            if (rv) m_pc = t;
        end else if (m_req) begin
`ifdef PC_DELAY_SLOT_EN
            if (bus.imem_ack) begin
                m_inst = bus.imem_data;
                m_ipc  = m_pc;
                m_pc   = rv ? t : (m_pend ? m_tgt : m_pc + 32'd4);
                m_pend = 1'b0;
                m_hold = 1'b1;
                m_req  = 1'b0;
            end else if (rv) begin
                m_pend = 1'b1;
                m_tgt  = t;
            end
`else
            if (bus.imem_ack) begin
                if (rv) begin
                    m_pc = t; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_pc = m_tgt; m_pend = 1'b0;
                end else begin
                    m_inst = bus.imem_data;
                    m_ipc  = m_pc;
                    m_pc   = m_pc + 32'd4;
                    m_hold = 1'b1;
                    m_req  = 1'b0;
                end
            end else if (rv) begin
                m_pend = 1'b1;
                m_tgt  = t;
            end
`endif
        end else if (m_hold) begin
`ifdef PC_DELAY_SLOT_EN
            if (rv) m_pc = t;
            if (bus.inst_ready) begin
                m_hold = 1'b0; m_cnt = m_cnt + 32'd1; m_req = 1'b1;
            end
`else
            if (rv) begin
                m_hold = 1'b0; m_pc = t; m_req = 1'b1;
            end else if (bus.inst_ready) begin
                m_hold = 1'b0; m_cnt = m_cnt + 32'd1; m_req = 1'b1;
            end
`endif
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(bus.imem_req), 32'(m_req));
        if (m_req)  chk("imem_addr", bus.imem_addr, m_pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(m_hold));
        if (m_hold) begin
            chk("inst", bus.inst, m_inst);
            chk("inst_pc", bus.inst_pc, m_ipc);
        end
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    // One clock: the model consumes the inputs applied now, then outputs are
    // compared on the following falling edge and strobes are cleared.
    task automatic step();
        model_adv();
        @(negedge clk);
        compare_all();
        bus.redir_valid = 1'b0;
        bus.imem_ack    = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.imem_ack = 1'b0; bus.imem_data = 32'd0; bus.inst_ready = 1'b0;
        bus.redir_valid = 1'b0; bus.redir_sel = 2'b00; bus.redir_pc = 32'd0; bus.redir_imm = 26'd0;
    endtask

    task automatic reset_dut(input bit check_literals);
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        mem_busy = 1'b0;
        repeat (3) @(negedge clk);
        if (check_literals) begin
            chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
            chk("rst_imem_addr", bus.imem_addr, 32'h0040_0020);
            chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
            chk("rst_inst", bus.inst, 32'd0);
            chk("rst_inst_pc", bus.inst_pc, 32'd0);
            chk("rst_fetch_count", fetch_count, 32'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic mem_drive();
        if (bus.imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = int'($urandom_range(0, 3));
            end
            if (mem_wait == 0) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = $urandom;
                mem_busy      = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        bus.inst_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
            bus.redir_valid = 1'b1;
            bus.redir_sel   = 2'($urandom_range(0, 3));
            bus.redir_pc    = 32'h0040_0000 | (32'($urandom_range(0, 1023)) << 2);
            bus.redir_imm   = 26'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Zero-wait memory, decode always ready.
        reset_dut(1'b1);
        for (int k = 1; k <= 7; k++) begin
            bus.imem_ack   = bus.imem_req;
            bus.imem_data  = 32'hA000_0000 + 32'(k);
            bus.inst_ready = 1'b1;
            step();
            if (bus.imem_req) begin
                addr_q.push_back(bus.imem_addr);
                cyc_q.push_back(k);
            end
        end
        chk("seq_req_count", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() >= 3) begin
            chk("seq_addr0", addr_q[0], 32'h0040_0020);
            chk("seq_addr1", addr_q[1], 32'h0040_0024);
            chk("seq_addr2", addr_q[2], 32'h0040_0028);
            chk("seq_spacing", 32'(cyc_q[2] - cyc_q[0]), 32'd4);
        end
        chk("seq_fetch_count", fetch_count, 32'd3);

        // Branch arriving while an instruction is held.
        reset_dut(1'b0);
        step();
        bus.imem_ack = 1'b1; bus.imem_data = 32'h1111_1111;
        step();
        chk("br_hold_valid", 32'(bus.inst_valid), 32'd1);
        bus.inst_ready = 1'b1;
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b01; bus.redir_pc = 32'h0040_0030;
`ifdef PC_DELAY_SLOT_EN
        bus.redir_imm = 26'h000_0004;
        step();
        chk("br_ds_count", fetch_count, 32'd1);
        chk("br_ds_req", 32'(bus.imem_req), 32'd1);
        chk("br_ds_addr", bus.imem_addr, 32'h0040_0044);
`else
        bus.redir_imm = 26'h000_FFFE;
        step();
        chk("br_sq_valid", 32'(bus.inst_valid), 32'd0);
        chk("br_sq_req", 32'(bus.imem_req), 32'd1);
        chk("br_sq_addr", bus.imem_addr, 32'h0040_002C);
        chk("br_sq_count", fetch_count, 32'd0);
`endif

        // Jump arriving while a request is outstanding.
        reset_dut(1'b0);
        bus.inst_ready = 1'b0;
        step();
        bus.redir_valid = 1'b1; bus.redir_sel = 2'b10;
        bus.redir_pc = 32'h0040_0040; bus.redir_imm = 26'h010_0010;
        step();
        chk("jmp_wait_addr1", bus.imem_addr, 32'h0040_0020);
        step();
        chk("jmp_wait_addr2", bus.imem_addr, 32'h0040_0020);
        chk("jmp_wait_req", 32'(bus.imem_req), 32'd1);
        bus.imem_ack = 1'b1; bus.imem_data = 32'hDEAD_BEEF;
        step();
`ifdef PC_DELAY_SLOT_EN
        chk("jmp_ds_valid", 32'(bus.inst_valid), 32'd1);
        chk("jmp_ds_inst", bus.inst, 32'hDEAD_BEEF);
        chk("jmp_ds_inst_pc", bus.inst_pc, 32'h0040_0020);
        bus.inst_ready = 1'b1;
        step();
        chk("jmp_ds_addr", bus.imem_addr, 32'h0040_0040);
`else
        chk("jmp_sq_valid", 32'(bus.inst_valid), 32'd0);
        chk("jmp_sq_req", 32'(bus.imem_req), 32'd1);
        chk("jmp_sq_addr", bus.imem_addr, 32'h0040_0040);
`endif

        // Randomized traffic with an asynchronous reset pulse mid-request.
        reset_dut(1'b0);
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                for (int w = 0; w < 40 && !bus.imem_req; w++) begin
                    mem_drive();
                    step();
                end
                chk("rstmid_found_req", 32'(bus.imem_req), 32'd1);
                clear_inputs();
                #2 rst_n = 1'b0;
                #1;
                chk("rstmid_imem_req", 32'(bus.imem_req), 32'd0);
                chk("rstmid_inst_valid", 32'(bus.inst_valid), 32'd0);
                chk("rstmid_imem_addr", bus.imem_addr, 32'h0040_0020);
                model_reset();
                mem_busy = 1'b0;
                #1 rst_n = 1'b1;
                step();
                chk("rstmid_restart_addr", bus.imem_addr, 32'h0040_0020);
            end
            mem_drive();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
